qrs_peak_search: RTL and testbench

Peak-search stage directly upstream of the QRS detection FSM. It consumes the short-window absolute-difference stream and tracks the running maximum during the initial learning period. Once search is enabled, it opens a fixed-length window on each threshold crossing and reports the window maximum with a one-cycle extremum pulse. It then applies a refractory period before re-arming. Its outputs drive the FSM's `i_abs_diff_short_max`, `i_abs_diff_short_valid` and `i_extremum_found`; the FSM's `o_qrs_search_en` and `o_qrs_threshold` feed back into it.

---
 rtl/qrs_pkg.sv | 20 ++
 rtl/sample_window_ctr.sv | 42 ++++
 rtl/qrs_peak_search.sv | 148 ++++++++++++++
 tb/tb_qrs_peak_search.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/qrs_pkg.sv
// Shared definitions for the QRS peak-search stage and the detection FSM.
package qrs_pkg;

  // Sampling rate the default window and refractory lengths are derived from.
  localparam int FS_HZ           = 360;
  // 100 ms search window at FS_HZ.
  localparam int WIN_LEN_DEF     = 36;
  // 200 ms refractory period at FS_HZ.
  localparam int REFRACT_LEN_DEF = 72;

  typedef enum logic [2:0] {
    IDLE,
    LEARN,
    ARMED,
    WINDOW,
    REPORT,
    REFRACT
  } search_state_t;

endpackage

// File: rtl/sample_window_ctr.sv
// Accepted-sample up-counter shared by the search window and the refractory
// period. A clear and an increment in the same cycle load the value 1.
module sample_window_ctr #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_nrst,
  input  logic                 i_clr,
  input  logic                 i_inc,
  input  logic [CNT_WIDTH-1:0] i_tc,
  output logic [CNT_WIDTH-1:0] o_count,
  output logic                 o_tc_next
);

  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] count_d;
  logic [CNT_WIDTH-1:0] count_q;

  // Next count: optional clear, then optional increment on top of it.
  always_comb begin
    count_d = i_clr ? '0 : count_q;
    if (i_inc) begin
      count_d = count_d + ONE;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_count   = count_q;
  // High when one more increment reaches the terminal count; derived from the
  // register only so callers can use it without a combinational loop.
  assign o_tc_next = ((count_q + ONE) == i_tc);

endmodule

// File: rtl/qrs_peak_search.sv
// Peak search ahead of the QRS FSM: running max while learning, then a
// fixed-length window per threshold crossing, a one-cycle extremum pulse at
// window close, and a refractory period before re-arming.
module qrs_peak_search
  import qrs_pkg::*;
#(
  parameter int DATA_WIDTH  = 11,
  parameter int WIN_LEN     = WIN_LEN_DEF,
  parameter int REFRACT_LEN = REFRACT_LEN_DEF,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic                  i_ce,
  input  logic [DATA_WIDTH-1:0] i_abs_diff,
  input  logic                  i_abs_diff_valid,
  input  logic                  i_search_en,
  input  logic [DATA_WIDTH-1:0] i_qrs_threshold,
  output logic [DATA_WIDTH-1:0] o_abs_diff_short_max,
  output logic                  o_abs_diff_short_valid,
  output logic                  o_extremum_found,
  output logic [CNT_WIDTH-1:0]  o_peak_offset
);

  localparam logic [CNT_WIDTH-1:0] WIN_TC = CNT_WIDTH'(WIN_LEN);
  localparam logic [CNT_WIDTH-1:0] REF_TC = CNT_WIDTH'(REFRACT_LEN);

  search_state_t state_d, state_q;

  logic [DATA_WIDTH-1:0] max_d, max_q;
  logic [CNT_WIDTH-1:0]  offset_d, offset_q;
  logic                  valid_d, valid_q;
  logic                  found_d, found_q;

  logic                  accept;
  logic                  crossing;
  logic                  bigger;

  logic                  ctr_clr;
  logic                  ctr_inc;
  logic [CNT_WIDTH-1:0]  ctr_tc;
  logic [CNT_WIDTH-1:0]  ctr_count;
  logic                  ctr_tc_next;

  assign accept   = i_ce & i_abs_diff_valid;
  assign crossing = accept && (i_abs_diff > i_qrs_threshold);
  assign bigger   = i_abs_diff > max_q;
  assign ctr_tc   = (state_q == REFRACT) ? REF_TC : WIN_TC;

  sample_window_ctr #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_ctr (
    .i_clk     (i_clk),
    .i_nrst    (i_nrst),
    .i_clr     (ctr_clr),
    .i_inc     (ctr_inc),
    .i_tc      (ctr_tc),
    .o_count   (ctr_count),
    .o_tc_next (ctr_tc_next)
  );

  // Next-state, max/offset tracking and counter control.
  always_comb begin
    state_d  = state_q;
    max_d    = max_q;
    offset_d = offset_q;
    valid_d  = valid_q;
    ctr_clr  = 1'b0;
    ctr_inc  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          valid_d = 1'b1;
          max_d   = i_abs_diff;
          state_d = LEARN;
        end
      end
      LEARN: begin
        if (accept && bigger) begin
          max_d = i_abs_diff;
        end
        if (i_search_en) begin
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (i_search_en && crossing) begin
          max_d    = i_abs_diff;
          offset_d = '0;
          ctr_clr  = 1'b1;
          ctr_inc  = 1'b1;
          state_d  = (WIN_LEN == 1) ? REPORT : WINDOW;
        end
      end
      WINDOW: begin
        if (accept) begin
          ctr_inc = 1'b1;
          if (bigger) begin
            max_d    = i_abs_diff;
            offset_d = ctr_count;
          end
          if (ctr_tc_next) begin
            state_d = REPORT;
          end
        end
      end
      REPORT: begin
        ctr_clr = 1'b1;
        state_d = (REFRACT_LEN == 0) ? ARMED : REFRACT;
      end
      REFRACT: begin
        if (accept) begin
          ctr_inc = 1'b1;
          if (ctr_tc_next) begin
            state_d = ARMED;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    found_d = (state_d == REPORT);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      state_q  <= IDLE;
      max_q    <= '0;
      offset_q <= '0;
      valid_q  <= 1'b0;
      found_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      max_q    <= max_d;
      offset_q <= offset_d;
      valid_q  <= valid_d;
      found_q  <= found_d;
    end
  end

  assign o_abs_diff_short_max   = max_q;
  assign o_abs_diff_short_valid = valid_q;
  assign o_extremum_found       = found_q;
  assign o_peak_offset          = offset_q;

endmodule

// File: tb/tb_qrs_peak_search.sv
// Self-checking bench for qrs_peak_search: directed scenarios on a WIN_LEN=4 /
// REFRACT_LEN=3 instance plus a randomized run comparing that instance and a
// WIN_LEN=1 / REFRACT_LEN=0 instance against a window-buffer reference model.
module tb_qrs_peak_search;

  localparam int P_IDLE    = 0;
  localparam int P_LEARN   = 1;
  localparam int P_ARMED   = 2;
  localparam int P_WINDOW  = 3;
  localparam int P_REPORT  = 4;
  localparam int P_REFRACT = 5;

  logic        clk = 1'b0;
  logic        nrst;
  logic        ce;
  logic        vld;
  logic [10:0] sample;
  logic        en;
  logic [10:0] thr;

  logic [10:0] max0, max1;
  logic        valid0, valid1;
  logic        found0, found1;
  logic [7:0]  off0, off1;

  logic [10:0] d_max[2];
  logic        d_valid[2];
  logic        d_found[2];
  logic [7:0]  d_off[2];

  int checks = 0;
  int passes = 0;

  int m_ph[2];
  int m_max[2];
  int m_off[2];
  int m_valid[2];
  int m_pulse[2];
  int m_left[2];
  int m_wn[2];
  int m_win[2][64];
  int win_len[2] = '{4, 1};
  int ref_len[2] = '{3, 0};

  always #5 clk = ~clk;

  qrs_peak_search #(.DATA_WIDTH(11), .WIN_LEN(4), .REFRACT_LEN(3), .CNT_WIDTH(8)) u_dut0 (
    .i_clk(clk), .i_nrst(nrst), .i_ce(ce), .i_abs_diff(sample), .i_abs_diff_valid(vld),
    .i_search_en(en), .i_qrs_threshold(thr), .o_abs_diff_short_max(max0),
    .o_abs_diff_short_valid(valid0), .o_extremum_found(found0), .o_peak_offset(off0));

  qrs_peak_search #(.DATA_WIDTH(11), .WIN_LEN(1), .REFRACT_LEN(0), .CNT_WIDTH(8)) u_dut1 (
    .i_clk(clk), .i_nrst(nrst), .i_ce(ce), .i_abs_diff(sample), .i_abs_diff_valid(vld),
    .i_search_en(en), .i_qrs_threshold(thr), .o_abs_diff_short_max(max1),
    .o_abs_diff_short_valid(valid1), .o_extremum_found(found1), .o_peak_offset(off1));

  assign d_max[0] = max0;     assign d_max[1] = max1;
  assign d_valid[0] = valid0; assign d_valid[1] = valid1;
  assign d_found[0] = found0; assign d_found[1] = found1;
  assign d_off[0] = off0;     assign d_off[1] = off1;

  // Reference model: the window is kept as a list of samples and its max and
  // first-occurrence index are recomputed from that list on every sample.
  task automatic model_step(input int k);
    int  s;
    bit  acc;
    bit  add;
    s   = int'(sample);
    acc = ce && vld;
    add = 1'b0;
    m_pulse[k] = 0;
    if (!nrst) begin
      m_ph[k] = P_IDLE; m_max[k] = 0; m_off[k] = 0; m_valid[k] = 0;
      m_left[k] = 0; m_wn[k] = 0;
      return;
    end
    case (m_ph[k])
      P_IDLE: if (acc) begin m_valid[k] = 1; m_max[k] = s; m_ph[k] = P_LEARN; end
      P_LEARN: begin
        if (acc && s > m_max[k]) m_max[k] = s;
        if (en) m_ph[k] = P_ARMED;
      end
      P_ARMED: if (acc && en && s > int'(thr)) begin m_wn[k] = 0; add = 1'b1; end
      P_WINDOW: if (acc) add = 1'b1;
      P_REPORT: begin
        m_left[k] = ref_len[k];
        m_ph[k] = (ref_len[k] == 0) ? P_ARMED : P_REFRACT;
      end
      P_REFRACT: if (acc) begin
        m_left[k]--;
        if (m_left[k] == 0) m_ph[k] = P_ARMED;
      end
      default: m_ph[k] = P_IDLE;
    endcase
    if (add) begin
      m_win[k][m_wn[k]] = s;
      m_wn[k]++;
      m_max[k] = m_win[k][0];
      m_off[k] = 0;
      for (int i = 1; i < m_wn[k]; i++) begin
        if (m_win[k][i] > m_max[k]) begin m_max[k] = m_win[k][i]; m_off[k] = i; end
      end
      if (m_wn[k] == win_len[k]) begin m_ph[k] = P_REPORT; m_pulse[k] = 1; end
      else m_ph[k] = P_WINDOW;
    end
  endtask

  // Drive one cycle of inputs, advance the model with them, sample 1 ns later.
  task automatic applyStimulus(input logic r_n, input logic c, input logic v,
                               input int s, input logic e, input int t);
    nrst = r_n; ce = c; vld = v; sample = 11'(s); en = e; thr = 11'(t);
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b1, $urandom_range(1, 2047), 1'b1, 0);
    checks++; if (max0 !== 11'd0) $display("[TB] FAIL reset_max: got %0d want 0", max0); else passes++;
    checks++; if (valid0 !== 1'b0) $display("[TB] FAIL reset_valid: got %0b want 0", valid0); else passes++;
    checks++; if (found0 !== 1'b0) $display("[TB] FAIL reset_found: got %0b want 0", found0); else passes++;
    checks++; if (off0 !== 8'd0) $display("[TB] FAIL reset_offset: got %0d want 0", off0); else passes++;
    checks++; if (valid1 !== 1'b0) $display("[TB] FAIL reset_valid_w1: got %0b want 0", valid1); else passes++;
    applyStimulus(1'b1, 1'b1, 1'b1, 5, 1'b0, 0);
    checks++; if (valid0 !== 1'b1) $display("[TB] FAIL first_valid: got %0b want 1", valid0); else passes++;
    checks++; if (max0 !== 11'd5) $display("[TB] FAIL first_max: got %0d want 5", max0); else passes++;
  endtask

  task automatic test_learning();
    int vals[3] = '{40, 12, 40};
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, vals[i], 1'b0, 0);
      checks++; if (max0 !== 11'd40) $display("[TB] FAIL learn_max[%0d]: got %0d want 40", i, max0); else passes++;
      checks++; if (found0 !== 1'b0) $display("[TB] FAIL learn_nopulse[%0d]: got %0b want 0", i, found0); else passes++;
    end
  endtask

  task automatic test_window();
    int vals[5]  = '{10, 25, 60, 30, 60};
    int emax[5]  = '{40, 25, 60, 60, 60};
    int efnd[5]  = '{0, 0, 0, 0, 1};
    applyStimulus(1'b1, 1'b1, 1'b0, 0, 1'b1, 20);
    checks++; if (max0 !== 11'd40) $display("[TB] FAIL arm_hold_max: got %0d want 40", max0); else passes++;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, vals[i], 1'b1, 20);
      checks++; if (max0 !== 11'(emax[i])) $display("[TB] FAIL win_max[%0d]: got %0d want %0d", i, max0, emax[i]); else passes++;
      checks++; if (found0 !== 1'(efnd[i])) $display("[TB] FAIL win_pulse[%0d]: got %0b want %0d", i, found0, efnd[i]); else passes++;
    end
    checks++; if (off0 !== 8'd1) $display("[TB] FAIL win_offset: got %0d want 1", off0); else passes++;
  endtask

  task automatic test_refract();
    applyStimulus(1'b1, 1'b1, 1'b0, 0, 1'b1, 20);
    checks++; if (found0 !== 1'b0) $display("[TB] FAIL pulse_width: got %0b want 0", found0); else passes++;
    checks++; if (max0 !== 11'd60 || off0 !== 8'd1) $display("[TB] FAIL report_hold: got max %0d off %0d want 60/1", max0, off0); else passes++;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 100, 1'b1, 20);
      checks++; if (max0 !== 11'd60) $display("[TB] FAIL refract_max[%0d]: got %0d want 60", i, max0); else passes++;
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 100, 1'b1, 20);
    checks++; if (max0 !== 11'd100 || off0 !== 8'd0) $display("[TB] FAIL rearm_open: got max %0d off %0d want 100/0", max0, off0); else passes++;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b1, 5, 1'b1, 20);
    checks++; if (found0 !== 1'b1) $display("[TB] FAIL rearm_pulse: got %0b want 1", found0); else passes++;
  endtask

  task automatic test_search_en_drop();
    int vals[3] = '{70, 10, 20};
    int npulse = 0;
    applyStimulus(1'b1, 1'b1, 1'b0, 0, 1'b1, 20);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b1, 0, 1'b1, 20);
    applyStimulus(1'b1, 1'b1, 1'b1, 50, 1'b1, 20);
    checks++; if (max0 !== 11'd50) $display("[TB] FAIL drop_open: got %0d want 50", max0); else passes++;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b1, vals[i], 1'b0, 20);
    checks++; if (found0 !== 1'b1 || max0 !== 11'd70 || off0 !== 8'd1)
      $display("[TB] FAIL drop_complete: got pulse %0b max %0d off %0d want 1/70/1", found0, max0, off0); else passes++;
    applyStimulus(1'b1, 1'b1, 1'b0, 0, 1'b0, 20);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b1, 0, 1'b0, 20);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 200, 1'b0, 20);
      if (found0 === 1'b1) npulse++;
    end
    checks++; if (npulse != 0 || max0 !== 11'd70) $display("[TB] FAIL disabled_crossing: got pulses %0d max %0d want 0/70", npulse, max0); else passes++;
  endtask

  task automatic test_ce_gating();
    applyStimulus(1'b1, 1'b1, 1'b1, 30, 1'b1, 20);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b1, 500, 1'b1, 20);
    checks++; if (max0 !== 11'd30 || found0 !== 1'b0) $display("[TB] FAIL ce_hold: got max %0d pulse %0b want 30/0", max0, found0); else passes++;
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1, 1'b1, 20);
    checks++; if (found0 !== 1'b0) $display("[TB] FAIL ce_count_early: got %0b want 0", found0); else passes++;
    applyStimulus(1'b1, 1'b1, 1'b1, 1, 1'b1, 20);
    checks++; if (found0 !== 1'b1 || max0 !== 11'd30 || off0 !== 8'd0)
      $display("[TB] FAIL ce_close: got pulse %0b max %0d off %0d want 1/30/0", found0, max0, off0); else passes++;
    applyStimulus(1'b1, 1'b1, 1'b0, 0, 1'b1, 20);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b1, 0, 1'b1, 20);
    applyStimulus(1'b1, 1'b1, 1'b1, 40, 1'b1, 20);
    checks++; if (max0 !== 11'd40) $display("[TB] FAIL pre_reset_open: got %0d want 40", max0); else passes++;
    applyStimulus(1'b0, 1'b1, 1'b1, 99, 1'b1, 20);
    checks++; if (max0 !== 11'd0 || valid0 !== 1'b0 || found0 !== 1'b0 || off0 !== 8'd0)
      $display("[TB] FAIL midwin_reset: got max %0d valid %0b pulse %0b off %0d want all 0", max0, valid0, found0, off0); else passes++;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 0, 1'b1, 20);
      checks++; if (found0 !== 1'b0 || valid0 !== 1'b0) $display("[TB] FAIL post_reset[%0d]: got pulse %0b valid %0b want 0/0", i, found0, valid0); else passes++;
    end
  endtask

  task automatic test_random();
    int s;
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
    for (int n = 0; n < 2000; n++) begin
      s = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 2047)) : int'($urandom_range(0, 63));
      applyStimulus($urandom_range(0, 199) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                    s, $urandom_range(0, 9) != 0, int'($urandom_range(10, 50)));
      for (int k = 0; k < 2; k++) begin
        checks++; if (d_max[k] !== 11'(m_max[k])) $display("[TB] FAIL rnd_max%0d@%0d: got %0d want %0d", k, n, d_max[k], m_max[k]); else passes++;
        checks++; if (d_valid[k] !== 1'(m_valid[k])) $display("[TB] FAIL rnd_valid%0d@%0d: got %0b want %0d", k, n, d_valid[k], m_valid[k]); else passes++;
        checks++; if (d_found[k] !== 1'(m_pulse[k])) $display("[TB] FAIL rnd_pulse%0d@%0d: got %0b want %0d", k, n, d_found[k], m_pulse[k]); else passes++;
        checks++; if (d_off[k] !== 8'(m_off[k])) $display("[TB] FAIL rnd_offset%0d@%0d: got %0d want %0d", k, n, d_off[k], m_off[k]); else passes++;
      end
    end
  endtask

  initial begin
    nrst = 1'b0; ce = 1'b0; vld = 1'b0; sample = '0; en = 1'b0; thr = '0;
    for (int k = 0; k < 2; k++) begin
      m_ph[k] = P_IDLE; m_max[k] = 0; m_off[k] = 0; m_valid[k] = 0;
      m_pulse[k] = 0; m_left[k] = 0; m_wn[k] = 0;
    end
    test_reset();
    test_learning();
    test_window();
    test_refract();
    test_search_en_drop();
    test_ce_gating();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
